// File: rtl/bus_gate_arbiter.sv
// Round-robin owner of the four shared-bus gate selects (PC, MDR, ALU, MARMUX).
// Grants one gate at a time, with a hold limit, per-owner lock and a turnaround gap.
module bus_gate_arbiter #(
  parameter int unsigned MAX_HOLD   = 8,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [3:0] req,
  input  logic [3:0] lock,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] owner_id,
  output logic       bus_busy,
  output logic       preempt
);

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned OWN_W  = 2;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned TURN_W = 2;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_LAST =
    (TURNAROUND > 0) ? TURN_W'(TURNAROUND - 1) : TURN_W'(0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic [N_REQ-1:0]  gate_q,     gate_d;
  logic [OWN_W-1:0]  owner_q,    owner_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
  logic              busy_q,     busy_d;
  logic              preempt_q,  preempt_d;

  logic [OWN_W-1:0]  win_c;
  logic [OWN_W-1:0]  idx_c;
  logic [N_REQ-1:0]  owner_bit_c;
  logic              others_wait_c;
  logic              owner_lock_c;

  // Round-robin search starting one past the current owner; the nearest hit wins.
  always_comb begin
    win_c = owner_q;
    idx_c = owner_q;
    for (int k = N_REQ; k >= 1; k--) begin
      idx_c = owner_q + OWN_W'(k);
      if (req[idx_c]) win_c = idx_c;
    end
  end

  assign owner_bit_c   = 4'b0001 << owner_q;
  assign others_wait_c = |(req & ~owner_bit_c);
  assign owner_lock_c  = lock[owner_q] & req[owner_q];

  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    preempt_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gate_d     = 4'b0001 << win_c;
          owner_d    = win_c;
          hold_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (!req[owner_q] ||
            (hold_cnt_q == HOLD_LAST && others_wait_c && !owner_lock_c)) begin
          gate_d     = '0;
          preempt_d  = req[owner_q];
          turn_cnt_d = '0;
          state_d    = (TURNAROUND > 0) ? ST_TURN : ST_IDLE;
        end else if (hold_cnt_q != HOLD_LAST) begin
          // Saturating at the limit lets a lock release preempt on the very next edge.
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      ST_TURN: begin
        if (turn_cnt_q == TURN_LAST) begin
          state_d = ST_IDLE;
        end else begin
          turn_cnt_d = turn_cnt_q + TURN_W'(1);
        end
      end

      default: begin
        gate_d  = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = |gate_d;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      gate_q     <= '0;
      owner_q    <= OWN_W'(N_REQ - 1);
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      busy_q     <= busy_d;
      preempt_q  <= preempt_d;
    end
  end

  assign GatePC     = gate_q[0];
  assign GateMDR    = gate_q[1];
  assign GateALU    = gate_q[2];
  assign GateMARMUX = gate_q[3];
  assign owner_id   = owner_q;
  assign bus_busy   = busy_q;
  assign preempt    = preempt_q;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed bench for bus_gate_arbiter: expected per-cycle outputs are queued with the
// stimulus and popped against the DUT after each edge (TURNAROUND=1 and TURNAROUND=0 copies).
module tb_bus_gate_arbiter;

  logic       Clk;
  logic       Reset_n;
  logic [3:0] req;
  logic [3:0] lock;

  logic       g_pc, g_mdr, g_alu, g_mar, busy1, pre1;
  logic [1:0] own1;
  logic       z_pc, z_mdr, z_alu, z_mar, busy0, pre0;
  logic [1:0] own0;

  int vectors;
  int miscompares;

  logic [7:0] q1[$];
  logic [7:0] q0[$];

  bus_gate_arbiter #(.MAX_HOLD(8), .TURNAROUND(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .lock(lock),
    .GatePC(g_pc), .GateMDR(g_mdr), .GateALU(g_alu), .GateMARMUX(g_mar),
    .owner_id(own1), .bus_busy(busy1), .preempt(pre1)
  );

  bus_gate_arbiter #(.MAX_HOLD(8), .TURNAROUND(0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .lock(lock),
    .GatePC(z_pc), .GateMDR(z_mdr), .GateALU(z_alu), .GateMARMUX(z_mar),
    .owner_id(own0), .bus_busy(busy0), .preempt(pre0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [7:0] ev(input logic [3:0] g, input logic [1:0] o,
                                    input logic b, input logic p);
    return {p, b, o, g};
  endfunction

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag);
    logic [7:0] e;
    cmp({tag, "_onehot"}, 8'($onehot0({g_mar, g_alu, g_mdr, g_pc})), 8'd1);
    cmp({tag, "_onehot0"}, 8'($onehot0({z_mar, z_alu, z_mdr, z_pc})), 8'd1);
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp({tag, "_ta1"}, {pre1, busy1, own1, g_mar, g_alu, g_mdr, g_pc}, e);
    end
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp({tag, "_ta0"}, {pre0, busy0, own0, z_mar, z_alu, z_mdr, z_pc}, e);
    end
  endtask

  task automatic step(input string tag);
    @(posedge Clk);
    #1;
    check_now(tag);
  endtask

  // Reset pulse placed mid-cycle; outputs must clear before any clock edge.
  task automatic pulse_reset(input string tag);
    #2;
    Reset_n = 1'b0;
    #1;
    q1.push_back(ev(4'b0000, 2'd3, 1'b0, 1'b0));
    q0.push_back(ev(4'b0000, 2'd3, 1'b0, 1'b0));
    check_now(tag);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset_n     = 1'b0;
    req         = 4'hF;
    lock        = 4'h0;

    // 1: reset values with all requests pending, then a single PC request.
    q1.push_back(ev(4'b0000, 2'd3, 1'b0, 1'b0));
    q0.push_back(ev(4'b0000, 2'd3, 1'b0, 1'b0));
    step("t1_reset");
    Reset_n = 1'b1;
    req     = 4'b0001;
    q1.push_back(ev(4'b0001, 2'd0, 1'b1, 1'b0));
    step("t1_grant");

    // 2: full rotation under constant contention.
    pulse_reset("t2_reset");
    req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 8; c++) begin
        q1.push_back(ev(4'(4'b0001 << k), 2'(k), 1'b1, 1'b0));
        step("t2_hold");
      end
      q1.push_back(ev(4'b0000, 2'(k), 1'b0, 1'b1));
      step("t2_preempt");
      q1.push_back(ev(4'b0000, 2'(k), 1'b0, 1'b0));
      step("t2_turn");
    end
    q1.push_back(ev(4'b0001, 2'd0, 1'b1, 1'b0));
    step("t2_wrap");
    req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      q1.push_back(ev(4'b0000, 2'd0, 1'b0, 1'b0));
      step("t2_drain");
    end

    // 3: short ALU request, voluntary release without preempt.
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      q1.push_back(ev(4'b0100, 2'd2, 1'b1, 1'b0));
      step("t3_alu");
    end
    req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      q1.push_back(ev(4'b0000, 2'd2, 1'b0, 1'b0));
      step("t3_idle");
    end

    // 4: locked PC holds past the limit; dropping the lock preempts at once.
    req  = 4'b0011;
    lock = 4'b0001;
    for (int c = 0; c < 25; c++) begin
      q1.push_back(ev(4'b0001, 2'd0, 1'b1, 1'b0));
      step("t4_locked");
    end
    lock = 4'b0000;
    q1.push_back(ev(4'b0000, 2'd0, 1'b0, 1'b1));
    step("t4_preempt");
    q1.push_back(ev(4'b0000, 2'd0, 1'b0, 1'b0));
    step("t4_turn");
    for (int c = 0; c < 2; c++) begin
      q1.push_back(ev(4'b0010, 2'd1, 1'b1, 1'b0));
      step("t4_mdr");
    end
    req = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      q1.push_back(ev(4'b0000, 2'd1, 1'b0, 1'b0));
      step("t4_release");
    end
    for (int c = 0; c < 2; c++) begin
      q1.push_back(ev(4'b0100, 2'd2, 1'b1, 1'b0));
      step("t4_alu");
    end

    // 5: async reset while ALU owns the bus; restart search from PC.
    req = 4'b1100;
    pulse_reset("t5_async");
    for (int c = 0; c < 2; c++) begin
      q1.push_back(ev(4'b0100, 2'd2, 1'b1, 1'b0));
      step("t5_alu");
    end

    // 6: handoff PC->MDR with and without a turnaround state.
    pulse_reset("t6_reset");
    req = 4'b0001;
    q1.push_back(ev(4'b0001, 2'd0, 1'b1, 1'b0));
    q0.push_back(ev(4'b0001, 2'd0, 1'b1, 1'b0));
    step("t6_pc");
    req = 4'b0010;
    q1.push_back(ev(4'b0000, 2'd0, 1'b0, 1'b0));
    q0.push_back(ev(4'b0000, 2'd0, 1'b0, 1'b0));
    step("t6_gap");
    q1.push_back(ev(4'b0000, 2'd0, 1'b0, 1'b0));
    q0.push_back(ev(4'b0010, 2'd1, 1'b1, 1'b0));
    step("t6_mdr0");
    q1.push_back(ev(4'b0010, 2'd1, 1'b1, 1'b0));
    q0.push_back(ev(4'b0010, 2'd1, 1'b1, 1'b0));
    step("t6_mdr1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
